// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter for a single-port SRAM; partial-byte writes via read-modify-write.
// Latency: grant is combinational; rvalid one cycle after grant (two for partial writes, plus mem_ready stalls).
// Backpressure: no grant while mem_ready=0 or during the RMW write cycle; requests are held until granted.
// Ports: clk/rst_n; per requester mN_req/we/be/addr/wdata in, mN_gnt/rvalid/rdata out;
//        SRAM side mem_wen_n/mem_addr/mem_wdata out, mem_rdata/mem_ready in (chip select tied active).
module sram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  input  logic [31:0]             m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic [31:0]             m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    mem_wen_n,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
);

  localparam int BW = DATA_WIDTH / 8;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] RMW_WRITE = 1'b1;

  logic [0:0]            state;
  logic                  last_gnt;   // 1 after reset so requester 0 wins the first tie
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [BW-1:0]         rmw_be;
  logic [DATA_WIDTH-1:0] rmw_wdata;
  logic [DATA_WIDTH-1:0] rmw_rword;
  logic                  rmw_owner;
  logic                  rmw_first;
  logic [1:0]            rvalid_q;

  logic                  can_grant;
  logic                  any_gnt;
  logic                  sel;
  logic                  sel_we;
  logic [BW-1:0]         sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_full;
  logic                  sel_partial;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  // Upper and sub-word address bits are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                              m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

  // rst_n gates the grant so nothing is accepted while reset is held.
  assign can_grant = rst_n && (state == IDLE) && mem_ready;
  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  assign sel       = m1_req && (!m0_req || !last_gnt);
  assign any_gnt   = can_grant && (m0_req || m1_req);
  assign m0_gnt    = any_gnt && !sel;
  assign m1_gnt    = any_gnt && sel;

  assign sel_we      = sel ? m1_we : m0_we;
  assign sel_be      = sel ? m1_be : m0_be;
  assign sel_addr    = sel ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
  assign sel_wdata   = sel ? m1_wdata : m0_wdata;
  assign sel_full    = &sel_be;
  assign sel_partial = sel_we && !sel_full && (|sel_be);

  // The word read in the grant cycle is only on mem_rdata during the first
  // RMW cycle; keep a copy in case mem_ready stalls the write.
  assign old_word = rmw_first ? mem_rdata : rmw_rword;

  always_comb begin
    merged = '0;
    for (int i = 0; i < BW; i++) begin
      merged[8*i +: 8] = rmw_be[i] ? rmw_wdata[8*i +: 8] : old_word[8*i +: 8];
    end
  end

  always_comb begin
    mem_wen_n = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == RMW_WRITE) begin
      mem_addr  = rmw_addr;
      mem_wdata = merged;
      mem_wen_n = !mem_ready;
    end else if (any_gnt) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      // Partial and zero-enable writes are reads in the grant cycle.
      mem_wen_n = !(sel_we && sel_full);
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      rmw_addr  <= '0;
      rmw_be    <= '0;
      rmw_wdata <= '0;
      rmw_rword <= '0;
      rmw_owner <= 1'b0;
      rmw_first <= 1'b0;
      rvalid_q  <= 2'b00;
    end else begin
      rvalid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (any_gnt) begin
            last_gnt <= sel;
            if (sel_partial) begin
              state     <= RMW_WRITE;
              rmw_addr  <= sel_addr;
              rmw_be    <= sel_be;
              rmw_wdata <= sel_wdata;
              rmw_owner <= sel;
              rmw_first <= 1'b1;
            end else begin
              rvalid_q <= sel ? 2'b10 : 2'b01;
            end
          end
        end
        default: begin
          rmw_first <= 1'b0;
          rmw_rword <= old_word;
          if (mem_ready) begin
            state    <= IDLE;
            rvalid_q <= rmw_owner ? 2'b10 : 2'b01;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, SRAM word-address width (2048 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width; byte lanes = DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for each requester m in {0,1}, port m_req  input  1  access request, held until granted.
REQ-006 SHALL have port m_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port m_be  input  DATA_WIDTH/8  byte enables, meaningful on writes only.
REQ-008 SHALL have port m_addr  input  32  byte address; word address = m_addr[ADDR_WIDTH+1:2]; upper bits ignored (aliasing).
REQ-009 SHALL have port m_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port m_gnt  output  1  request accepted this cycle.
REQ-011 SHALL have port m_rvalid  output  1  response valid, one cycle per grant.
REQ-012 SHALL have port m_rdata  output  DATA_WIDTH  read data, valid with m_rvalid.
REQ-013 SHALL have port mem_wen_n  output  1  SRAM write enable, active-low.
REQ-014 SHALL have ports mem_addr  output  ADDR_WIDTH  SRAM word address, and mem_wdata  output  DATA_WIDTH  SRAM write data.
REQ-015 SHALL have ports mem_rdata  input  DATA_WIDTH  SRAM read data, valid one cycle after a read access, and mem_ready  input  1  SRAM ready.

Function
REQ-016 SHALL implement FSM states IDLE, RMW_WRITE; chip select is tied active, so every cycle is an SRAM access (read when mem_wen_n=1).
REQ-017 In IDLE with mem_ready=1, SHALL assert exactly one m_gnt combinationally in the same cycle as the winning m_req; no gnt when mem_ready=0 or state is not IDLE.
REQ-018 Arbitration SHALL be round-robin: one requester wins alone; on simultaneous requests the requester not granted most recently wins; last-granted pointer updates on every grant.
REQ-019 Full write (m_we=1, m_be all ones) SHALL drive mem_wen_n=0, mem_addr, mem_wdata in the grant cycle; m_rvalid=1 the next cycle, rdata don't-care.
REQ-020 Read SHALL drive mem_wen_n=1 and mem_addr in the grant cycle; m_rvalid=1 next cycle with m_rdata=mem_rdata (latency 1).
REQ-021 Partial write (m_we=1, m_be not all ones, not zero) SHALL read the word in the grant cycle, latch addr/be/wdata/owner, go to RMW_WRITE.
REQ-022 In RMW_WRITE SHALL write merge (byte i = be[i] ? wdata byte i : mem_rdata byte i) to the latched address, assert owner m_rvalid the next cycle, return to IDLE; no grants in RMW_WRITE.
REQ-023 Write with m_be=0 SHALL be granted, perform no SRAM write (mem_wen_n=1), m_rvalid next cycle.
REQ-024 m_rvalid SHALL be pulsed only to the requester that was granted; back-to-back grants give back-to-back rvalids.
REQ-025 m_rdata SHALL be routed from mem_rdata for reads; its value with m_rvalid=0 is don't-care.
REQ-026 mem_ready low during RMW_WRITE SHALL hold state and defer the write until mem_ready=1.

Reset
REQ-027 While rst_n=0: state IDLE, m_gnt=0, m_rvalid=0, mem_wen_n=1, mem_addr=0, mem_wdata=0, pointer set so requester 0 wins the first tie.
REQ-028 Reset asserted mid-RMW SHALL abandon the write (no SRAM write, no rvalid); first cycle after deassertion behaves as IDLE.

Verification
REQ-029 Write 0xDEADBEEF, be=0xF, addr 0x10 from m0, then read 0x10 from m1 -> m1_rvalid one cycle after gnt with 0xDEADBEEF.
REQ-030 Both req every cycle after reset -> gnts alternate 0,1,0,1; each rvalid one cycle after its gnt.
REQ-031 Word 0x11223344 at 0x20, m0 writes 0xAABBCCDD be=0x5 -> no gnt for 2 cycles, read returns 0x11BB33DD.
REQ-032 mem_ready=0 for 3 cycles with m1_req high -> no gnt; gnt in the cycle mem_ready returns to 1.
REQ-033 rst_n low in RMW_WRITE of a be=0x1 write -> no rvalid, target word unchanged on later read.
REQ-034 Address 0x2000 (beyond 8 KB) read -> accesses word 0, returns word-0 data.
